xy_route_lock: RTL and testbench
================================

Name: xy_route_lock

Overview:
- Parametrised successor to the fixed-coordinate XY route-compute block.
- Sits at each router input port, between the input buffer and the switch allocator.
- Computes the XY output port from the header flit's destination and locks that port for the whole wormhole packet until the tail flit.
- Registers the flit, port number and one-hot port enable behind a valid/ready handshake.

Parameters:
- X_NODE_NUM, 4, mesh columns.
- Y_NODE_NUM, 4, mesh rows.
- X_NODE_NUM_WIDTH, 2, bits of the x coordinate.
- Y_NODE_NUM_WIDTH, 2, bits of the y coordinate.
- CUR_X, 0, this router's x address.
- CUR_Y, 1, this router's y address.
- FLIT_WIDTH, 16, flit width including 2 type bits; must be at least X_NODE_NUM_WIDTH+Y_NODE_NUM_WIDTH+2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- in_flit  in  FLIT_WIDTH  flit from the input buffer.
- in_valid  in  1  in_flit valid.
- in_ready  out  1  block accepts in_flit this cycle.
- out_flit  out  FLIT_WIDTH  registered flit.
- out_valid  out  1  out_flit, port_num and port_en valid.
- out_ready  in  1  switch allocator / crossbar consumes the output.
- port_num  out  4  output port: Lo=1, Eo=2, No=3, Wo=4, So=5; 0 = none.
- port_en  out  5  one-hot enable; bit0=L, bit1=E, bit2=W, bit3=S, bit4=N.
- locked  out  1  a packet is in progress (state LOCK).
- err  out  1  one-cycle pulse on a protocol or destination error.

Behaviour:
- Flit format:
  - [FLIT_WIDTH-1:FLIT_WIDTH-2] is the type: 2'b10 HDR, 2'b00 BODY, 2'b01 TAIL, 2'b11 HDR+TAIL (single-flit packet).
  - Destination y is in [Y_NODE_NUM_WIDTH-1:0].
  - Destination x is in [X_NODE_NUM_WIDTH+Y_NODE_NUM_WIDTH-1:Y_NODE_NUM_WIDTH].
- Route function (combinational, header flits only):
  - Compute xdiff=xd-CUR_X and ydiff=yd-CUR_Y as signed values, each one bit wider than its coordinate.
  - xdiff>0 -> Eo; xdiff<0 -> Wo; xdiff==0 and ydiff>0 -> So; ydiff<0 -> No; otherwise Lo.
- Destination check: xd>=X_NODE_NUM or yd>=Y_NODE_NUM makes the destination invalid. Such a header routes to Lo and pulses err.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - A flit is accepted when in_valid && in_ready; accepted flits appear on out_flit one cycle later.
  - out_* stay stable while out_valid && !out_ready.
  - With out_ready held high, one flit per cycle is sustained.
- State machine, states IDLE and LOCK; transitions occur only on an accepted flit.
  - IDLE + HDR: compute route, store it in locked_port, go to LOCK.
  - IDLE + HDR+TAIL: compute route, forward the flit, stay in IDLE.
  - IDLE + BODY or TAIL: drop the flit (not forwarded, out_valid not set), pulse err, stay in IDLE.
  - LOCK + BODY: forward with locked_port.
  - LOCK + TAIL: forward with locked_port, go to IDLE.
  - LOCK + HDR or HDR+TAIL: pulse err, recompute the route; HDR stays in LOCK with the new port, HDR+TAIL goes to IDLE.
- port_en is decoded from the registered port_num. Any port_num outside 1..5 gives port_en=0.
- locked=1 exactly when the state is LOCK.
- Reset values: state=IDLE, out_valid=0, out_flit=0, port_num=0, port_en=0, locked=0, err=0, locked_port=0.
- Reset mid-packet discards any partial packet and the held output; the next accepted flit is treated from IDLE.

Decomposition:
- Shared package noc_pkg:
  - Port codes Lo/Eo/No/Wo/So.
  - Flit type codes HDR/BODY/TAIL/HDR_TAIL.
  - port_en bit positions.
  - Header field offset functions.
- Sub-module xy_route_calc: purely combinational. Takes dest x/y, CUR_X/CUR_Y and widths; returns port_num and dest_err. It is reused by the lookahead router later.

Test Plan:
- Default params, HDR dest (x=2,y=1), then BODY, then TAIL, with out_ready=1 -> all three flits out with port_num=2 and port_en=5'b00010; locked 1 for two cycles, then 0.
- HDR+TAIL flits to (0,3), (0,0), (0,1), (3,2) -> port_num 5/3/1/2, port_en 01000/10000/00001/00010; locked stays 0.
- HDR dest (1,0), out_ready=0 for 3 cycles -> out_* held stable, in_ready=0; after release the flits drain in order with no loss or duplication.
- BODY in IDLE -> no output, err=1 for 1 cycle. HDR while in LOCK -> err pulse and the new route is used.
- CUR_X=2, CUR_Y=2, X/Y_NODE_NUM=3: HDR dest (3,0) -> err pulse, port_num=1.
- Assert rst low while in LOCK with out_valid=1 -> out_valid=0, port_en=0, locked=0 asynchronously. After release, a BODY is dropped with err and a HDR routes normally.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC port codes, flit type codes, port_en bit positions and header field helpers.
package noc_pkg;

    localparam logic [3:0] PORT_NONE = 4'd0;
    localparam logic [3:0] PORT_L    = 4'd1;
    localparam logic [3:0] PORT_E    = 4'd2;
    localparam logic [3:0] PORT_N    = 4'd3;
    localparam logic [3:0] PORT_W    = 4'd4;
    localparam logic [3:0] PORT_S    = 4'd5;

    localparam int EN_L = 0;
    localparam int EN_E = 1;
    localparam int EN_W = 2;
    localparam int EN_S = 3;
    localparam int EN_N = 4;

    typedef enum logic [1:0] {
        FT_BODY     = 2'b00,
        FT_TAIL     = 2'b01,
        FT_HDR      = 2'b10,
        FT_HDR_TAIL = 2'b11
    } flit_type_t;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    function automatic int y_lsb();
        return 0;
    endfunction

    function automatic int x_lsb(input int yw);
        return yw;
    endfunction

    function automatic int type_lsb(input int fw);
        return fw - 2;
    endfunction

    // Codes outside 1..5 decode to no enable at all.
    function automatic logic [4:0] port_onehot(input logic [3:0] p);
        return p == PORT_L ? 5'b1 << EN_L :
               p == PORT_E ? 5'b1 << EN_E :
               p == PORT_W ? 5'b1 << EN_W :
               p == PORT_S ? 5'b1 << EN_S :
               p == PORT_N ? 5'b1 << EN_N : 5'b0;
    endfunction

endpackage

// File: rtl/xy_route_calc.sv
// xy_route_calc: combinational XY dimension-order route with destination range check.
module xy_route_calc
    import noc_pkg::*;
#(
    parameter int XW         = 2,
    parameter int YW         = 2,
    parameter int X_NODE_NUM = 4,
    parameter int Y_NODE_NUM = 4,
    parameter int CUR_X      = 0,
    parameter int CUR_Y      = 1
) (
    input  logic [XW-1:0] i_xd,
    input  logic [YW-1:0] i_yd,
    output logic [3:0]    o_port_num,
    output logic          o_dest_err
);

    localparam logic [XW:0] CX = (XW+1)'(CUR_X);
    localparam logic [YW:0] CY = (YW+1)'(CUR_Y);
    localparam logic [XW:0] XN = (XW+1)'(X_NODE_NUM);
    localparam logic [YW:0] YN = (YW+1)'(Y_NODE_NUM);

    logic signed [XW:0] w_xdiff;
    logic signed [YW:0] w_ydiff;
    logic               w_xpos, w_xneg, w_ypos, w_yneg;

    assign w_xdiff    = $signed({1'b0, i_xd}) - $signed(CX);
    assign w_ydiff    = $signed({1'b0, i_yd}) - $signed(CY);
    assign w_xneg     = w_xdiff[XW];
    assign w_xpos     = !w_xdiff[XW] && |w_xdiff;
    assign w_yneg     = w_ydiff[YW];
    assign w_ypos     = !w_ydiff[YW] && |w_ydiff;
    assign o_dest_err = ({1'b0, i_xd} >= XN) || ({1'b0, i_yd} >= YN);

    // X is resolved fully before Y; unreachable destinations are sunk locally.
    assign o_port_num = o_dest_err ? PORT_L :
                        w_xpos     ? PORT_E :
                        w_xneg     ? PORT_W :
                        w_ypos     ? PORT_S :
                        w_yneg     ? PORT_N : PORT_L;

endmodule

// File: rtl/xy_route_lock.sv
// xy_route_lock: per-input-port XY route compute that locks the output port for a wormhole packet
// and registers flit, port number and one-hot enable behind a valid/ready handshake.
module xy_route_lock
    import noc_pkg::*;
#(
    parameter int X_NODE_NUM       = 4,
    parameter int Y_NODE_NUM       = 4,
    parameter int X_NODE_NUM_WIDTH = 2,
    parameter int Y_NODE_NUM_WIDTH = 2,
    parameter int CUR_X            = 0,
    parameter int CUR_Y            = 1,
    parameter int FLIT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            port_num,
    output logic [4:0]            port_en,
    output logic                  locked,
    output logic                  err
);

    localparam int XW = X_NODE_NUM_WIDTH;
    localparam int YW = Y_NODE_NUM_WIDTH;

    state_t                r_state, w_nstate;
    logic [FLIT_WIDTH-1:0] r_flit;
    logic                  r_valid;
    logic [3:0]            r_port_num;
    logic [3:0]            r_locked_port;
    logic                  r_err;

    flit_type_t            w_type;
    logic [XW-1:0]         w_xd;
    logic [YW-1:0]         w_yd;
    logic [3:0]            w_route;
    logic                  w_dest_err;
    logic                  w_accept;
    logic                  w_is_hdr;
    logic                  w_fwd;
    logic [3:0]            w_port;
    logic [3:0]            w_nlocked;
    logic                  w_err;

    assign w_type   = flit_type_t'(in_flit[type_lsb(FLIT_WIDTH) +: 2]);
    assign w_xd     = in_flit[x_lsb(YW) +: XW];
    assign w_yd     = in_flit[y_lsb() +: YW];
    assign w_is_hdr = w_type[1];
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    xy_route_calc #(
        .XW         (XW),
        .YW         (YW),
        .X_NODE_NUM (X_NODE_NUM),
        .Y_NODE_NUM (Y_NODE_NUM),
        .CUR_X      (CUR_X),
        .CUR_Y      (CUR_Y)
    ) u_calc (
        .i_xd       (w_xd),
        .i_yd       (w_yd),
        .o_port_num (w_route),
        .o_dest_err (w_dest_err)
    );

    // A header always recomputes the route; in LOCK it also flags the missing tail.
    always_comb begin
        w_nstate  = r_state;
        w_fwd     = 1'b0;
        w_port    = r_locked_port;
        w_nlocked = r_locked_port;
        w_err     = 1'b0;
        if (w_accept) begin
            if (w_is_hdr) begin
                w_fwd     = 1'b1;
                w_port    = w_route;
                w_nlocked = w_route;
                w_err     = w_dest_err || r_state == LOCK;
                w_nstate  = w_type == FT_HDR ? LOCK : IDLE;
            end else begin
                w_fwd    = r_state == LOCK;
                w_err    = r_state == IDLE;
                w_nstate = (r_state == LOCK && w_type == FT_BODY) ? LOCK : IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_valid       <= 1'b0;
            r_flit        <= '0;
            r_port_num    <= PORT_NONE;
            r_locked_port <= PORT_NONE;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_nstate;
            r_err         <= w_err;
            r_locked_port <= w_nlocked;
            r_valid       <= w_accept ? w_fwd : r_valid && !out_ready;
            if (w_accept && w_fwd) begin
                r_flit     <= in_flit;
                r_port_num <= w_port;
            end
        end
    end

    assign out_flit  = r_flit;
    assign out_valid = r_valid;
    assign port_num  = r_port_num;
    assign port_en   = port_onehot(r_port_num);
    assign locked    = r_state == LOCK;
    assign err       = r_err;

endmodule

// File: tb/tb_xy_route_lock.sv
// tb_xy_route_lock: table-driven directed checks of routing, locking, stall and reset behaviour.
module tb_xy_route_lock;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_flit = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_flit;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  port_num;
    logic [4:0]  port_en;
    logic        locked;
    logic        err;

    logic [15:0] d2_in_flit = '0;
    logic        d2_in_valid = 1'b0;
    logic        d2_in_ready;
    logic [15:0] d2_out_flit;
    logic        d2_out_valid;
    logic [3:0]  d2_port_num;
    logic [4:0]  d2_port_en;
    logic        d2_locked;
    logic        d2_err;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    xy_route_lock dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .port_num  (port_num),
        .port_en   (port_en),
        .locked    (locked),
        .err       (err)
    );

    xy_route_lock #(
        .X_NODE_NUM (3),
        .Y_NODE_NUM (3),
        .CUR_X      (2),
        .CUR_Y      (2)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (d2_in_flit),
        .in_valid  (d2_in_valid),
        .in_ready  (d2_in_ready),
        .out_flit  (d2_out_flit),
        .out_valid (d2_out_valid),
        .out_ready (out_ready),
        .port_num  (d2_port_num),
        .port_en   (d2_port_en),
        .locked    (d2_locked),
        .err       (d2_err)
    );

    typedef struct {
        logic [1:0] t;
        logic [1:0] x;
        logic [1:0] y;
        logic       v;
        logic [3:0] pn;
        logic [4:0] pe;
        logic       lk;
        logic       er;
    } vec_t;

    localparam logic [1:0] B = 2'b00, T = 2'b01, H = 2'b10, HT = 2'b11;

    function automatic logic [15:0] mk(input logic [1:0] t, input int tag, input logic [1:0] x, input logic [1:0] y);
        return {t, 10'(tag), x, y};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    vec_t v1[15];
    vec_t v2[6];
    logic [15:0] f;

    initial begin
        v1[0]  = '{H,  2'd2, 2'd1, 1, 4'd2, 5'b00010, 1, 0};
        v1[1]  = '{B,  2'd0, 2'd0, 1, 4'd2, 5'b00010, 1, 0};
        v1[2]  = '{T,  2'd0, 2'd0, 1, 4'd2, 5'b00010, 0, 0};
        v1[3]  = '{HT, 2'd0, 2'd3, 1, 4'd5, 5'b01000, 0, 0};
        v1[4]  = '{HT, 2'd0, 2'd0, 1, 4'd3, 5'b10000, 0, 0};
        v1[5]  = '{HT, 2'd0, 2'd1, 1, 4'd1, 5'b00001, 0, 0};
        v1[6]  = '{HT, 2'd3, 2'd2, 1, 4'd2, 5'b00010, 0, 0};
        v1[7]  = '{B,  2'd0, 2'd0, 0, 4'd0, 5'b00000, 0, 1};
        v1[8]  = '{T,  2'd0, 2'd0, 0, 4'd0, 5'b00000, 0, 1};
        v1[9]  = '{H,  2'd1, 2'd0, 1, 4'd2, 5'b00010, 1, 0};
        v1[10] = '{H,  2'd0, 2'd3, 1, 4'd5, 5'b01000, 1, 1};
        v1[11] = '{B,  2'd3, 2'd3, 1, 4'd5, 5'b01000, 1, 0};
        v1[12] = '{HT, 2'd0, 2'd0, 1, 4'd3, 5'b10000, 0, 1};
        v1[13] = '{H,  2'd0, 2'd0, 1, 4'd3, 5'b10000, 1, 0};
        v1[14] = '{T,  2'd2, 2'd2, 1, 4'd3, 5'b10000, 0, 0};

        v2[0]  = '{HT, 2'd3, 2'd0, 1, 4'd1, 5'b00001, 0, 1};
        v2[1]  = '{HT, 2'd0, 2'd2, 1, 4'd4, 5'b00100, 0, 0};
        v2[2]  = '{HT, 2'd2, 2'd1, 1, 4'd3, 5'b10000, 0, 0};
        v2[3]  = '{HT, 2'd2, 2'd3, 1, 4'd1, 5'b00001, 0, 1};
        v2[4]  = '{H,  2'd1, 2'd2, 1, 4'd4, 5'b00100, 1, 0};
        v2[5]  = '{T,  2'd0, 2'd0, 1, 4'd4, 5'b00100, 0, 0};

        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_port_num", 32'(port_num), 32'd0);
        chk("rst_port_en", 32'(port_en), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_flit", 32'(out_flit), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_err", 32'(err), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            in_flit  = mk(v1[i].t, i, v1[i].x, v1[i].y);
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(v1[i].v));
            if (v1[i].v) begin
                chk($sformatf("v%0d_flit", i), 32'(out_flit), 32'(mk(v1[i].t, i, v1[i].x, v1[i].y)));
                chk($sformatf("v%0d_port_num", i), 32'(port_num), 32'(v1[i].pn));
                chk($sformatf("v%0d_port_en", i), 32'(port_en), 32'(v1[i].pe));
            end
            chk($sformatf("v%0d_locked", i), 32'(locked), 32'(v1[i].lk));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(v1[i].er));
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_err", 32'(err), 32'd0);

        // Stall: header held on the output while the body waits upstream.
        @(negedge clk);
        in_flit  = mk(H, 100, 2'd1, 2'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("stall_hdr_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        in_flit   = mk(B, 101, 2'd0, 2'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
            chk($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_flit", c), 32'(out_flit), 32'(mk(H, 100, 2'd1, 2'd0)));
            chk($sformatf("stall%0d_port_num", c), 32'(port_num), 32'd2);
            chk($sformatf("stall%0d_port_en", c), 32'(port_en), 32'b00010);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_body_flit", 32'(out_flit), 32'(mk(B, 101, 2'd0, 2'd0)));
        chk("release_body_valid", 32'(out_valid), 32'd1);
        chk("release_body_port", 32'(port_num), 32'd2);
        @(negedge clk);
        in_flit = mk(T, 102, 2'd0, 2'd0);
        @(posedge clk); #1;
        chk("release_tail_flit", 32'(out_flit), 32'(mk(T, 102, 2'd0, 2'd0)));
        chk("release_tail_locked", 32'(locked), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("release_end_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a held, locked packet.
        @(negedge clk);
        out_ready = 1'b0;
        in_flit   = mk(H, 200, 2'd2, 2'd1);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        chk("prerst_locked", 32'(locked), 32'd1);
        chk("prerst_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_port_en", 32'(port_en), 32'd0);
        chk("arst_locked", 32'(locked), 32'd0);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        in_flit   = mk(B, 201, 2'd0, 2'd0);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        chk("postrst_body_valid", 32'(out_valid), 32'd0);
        chk("postrst_body_err", 32'(err), 32'd1);
        @(negedge clk);
        in_flit = mk(H, 202, 2'd0, 2'd3);
        @(posedge clk); #1;
        chk("postrst_hdr_valid", 32'(out_valid), 32'd1);
        chk("postrst_hdr_port", 32'(port_num), 32'd5);
        chk("postrst_hdr_locked", 32'(locked), 32'd1);
        chk("postrst_hdr_err", 32'(err), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;

        chk("d2_in_ready", 32'(d2_in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            d2_in_flit  = mk(v2[i].t, 300 + i, v2[i].x, v2[i].y);
            d2_in_valid = 1'b1;
            @(posedge clk); #1;
            f = mk(v2[i].t, 300 + i, v2[i].x, v2[i].y);
            chk($sformatf("d2v%0d_valid", i), 32'(d2_out_valid), 32'(v2[i].v));
            chk($sformatf("d2v%0d_flit", i), 32'(d2_out_flit), 32'(f));
            chk($sformatf("d2v%0d_port_num", i), 32'(d2_port_num), 32'(v2[i].pn));
            chk($sformatf("d2v%0d_port_en", i), 32'(d2_port_en), 32'(v2[i].pe));
            chk($sformatf("d2v%0d_locked", i), 32'(d2_locked), 32'(v2[i].lk));
            chk($sformatf("d2v%0d_err", i), 32'(d2_err), 32'(v2[i].er));
        end
        @(negedge clk);
        d2_in_valid = 1'b0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
